// File: rtl/tank_pkg.sv
// Shared types and constants for the per-player tank controller and its key decoder.
package tank_pkg;

    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    typedef enum logic {S_IDLE, S_MOVE} motion_t;

    typedef struct packed {
        logic [7:0] up;
        logic [7:0] down;
        logic [7:0] left;
        logic [7:0] right;
        logic [7:0] fire;
    } keymap_t;

    // USB HID usage codes: W S A D space, and the arrow cluster with enter.
    localparam keymap_t KEYS_WASD   = '{up: 8'h1A, down: 8'h16, left: 8'h04, right: 8'h07, fire: 8'h2C};
    localparam keymap_t KEYS_ARROWS = '{up: 8'h52, down: 8'h51, left: 8'h50, right: 8'h4F, fire: 8'h28};

    localparam logic [9:0] PF_X_MIN = 10'd0;
    localparam logic [9:0] PF_X_MAX = 10'd608;
    localparam logic [9:0] PF_Y_MIN = 10'd0;
    localparam logic [9:0] PF_Y_MAX = 10'd448;

endpackage

// File: rtl/tank_key_decode.sv
// Scans every HID keycode slot and flags which mapped keys are held; empty slots never match.
module tank_key_decode
    import tank_pkg::*;
#(
    parameter int NUM_KEYS = 6
) (
    input  logic [8*NUM_KEYS-1:0] keycodes,
    input  keymap_t               keymap,
    output logic                  up,
    output logic                  down,
    output logic                  left,
    output logic                  right,
    output logic                  fire
);

    logic [7:0] slot;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        up    = 1'b0;
        down  = 1'b0;
        left  = 1'b0;
        right = 1'b0;
        fire  = 1'b0;
        slot  = 8'h00;
        for (int i = 0; i < NUM_KEYS; i++) begin
            slot = keycodes[8*i +: 8];
            if (slot != 8'h00) begin
                if (slot == keymap.up)    up    = 1'b1;
                if (slot == keymap.down)  down  = 1'b1;
                if (slot == keymap.left)  left  = 1'b1;
                if (slot == keymap.right) right = 1'b1;
                if (slot == keymap.fire)  fire  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tank_ctrl.sv
// Per-player tank mover: resolves a direction from held keys, steps and clamps the position
// inside the playfield every frame, and rate-limits fire pulses.
module tank_ctrl
    import tank_pkg::*;
#(
    parameter logic [9:0] X_INIT   = 10'd32,
    parameter logic [9:0] Y_INIT   = 10'd416,
    parameter int         STEP     = 4,
    parameter logic [9:0] X_MIN    = PF_X_MIN,
    parameter logic [9:0] X_MAX    = PF_X_MAX,
    parameter logic [9:0] Y_MIN    = PF_Y_MIN,
    parameter logic [9:0] Y_MAX    = PF_Y_MAX,
    parameter int         NUM_KEYS = 6,
    parameter keymap_t    KEYMAP   = KEYS_WASD,
    parameter bit         STICKY   = 1'b0,
    parameter int         COOLDOWN = 30
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    output logic [9:0]            TankX,
    output logic [9:0]            TankY,
    output dir_t                  Facing,
    output logic                  Moving,
    output logic                  Blocked,
    output logic                  Fire
);

    localparam logic [9:0]  STEP_V = 10'(STEP);
    // Low-side thresholds carry an extra bit so MIN+STEP cannot wrap.
    localparam logic [10:0] X_LO   = {1'b0, X_MIN} + {1'b0, STEP_V};
    localparam logic [10:0] Y_LO   = {1'b0, Y_MIN} + {1'b0, STEP_V};
    localparam logic [9:0]  X_HI   = X_MAX - STEP_V;
    localparam logic [9:0]  Y_HI   = Y_MAX - STEP_V;
    localparam int          CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

    logic            key_up, key_down, key_left, key_right, key_fire;
    motion_t         state;
    dir_t            latched_dir;
    logic [CD_W-1:0] cooldown;
    logic            act_valid;
    dir_t            act_dir;
    logic [9:0]      next_x, next_y;
    logic            clamp;

    tank_key_decode #(.NUM_KEYS(NUM_KEYS)) u_decode (
        .keycodes (keycodes),
        .keymap   (KEYMAP),
        .up       (key_up),
        .down     (key_down),
        .left     (key_left),
        .right    (key_right),
        .fire     (key_fire)
    );

    // Fixed priority UP > DOWN > LEFT > RIGHT; a sticky tank falls back to its latched direction.
    always_comb begin
        act_valid = 1'b1;
        act_dir   = DIR_UP;
        if (key_up)                            act_dir = DIR_UP;
        else if (key_down)                     act_dir = DIR_DOWN;
        else if (key_left)                     act_dir = DIR_LEFT;
        else if (key_right)                    act_dir = DIR_RIGHT;
        else if (STICKY && state == S_MOVE)    act_dir = latched_dir;
        else                                   act_valid = 1'b0;
    end

    // Bounds are tested before stepping so the unsigned position never wraps.
    always_comb begin
        next_x = TankX;
        next_y = TankY;
        clamp  = 1'b0;
        case (act_dir)
            DIR_UP:    if ({1'b0, TankY} < Y_LO) begin next_y = Y_MIN; clamp = 1'b1; end
                       else next_y = TankY - STEP_V;
            DIR_DOWN:  if (TankY > Y_HI) begin next_y = Y_MAX; clamp = 1'b1; end
                       else next_y = TankY + STEP_V;
            DIR_LEFT:  if ({1'b0, TankX} < X_LO) begin next_x = X_MIN; clamp = 1'b1; end
                       else next_x = TankX - STEP_V;
            DIR_RIGHT: if (TankX > X_HI) begin next_x = X_MAX; clamp = 1'b1; end
                       else next_x = TankX + STEP_V;
            default:   ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_IDLE;
            latched_dir <= DIR_UP;
            TankX       <= X_INIT;
            TankY       <= Y_INIT;
            Facing      <= DIR_UP;
            Moving      <= 1'b0;
            Blocked     <= 1'b0;
            Fire        <= 1'b0;
            cooldown    <= '0;
        end else begin
            if (act_valid) begin
                state       <= S_MOVE;
                latched_dir <= act_dir;
                Facing      <= act_dir;
                TankX       <= next_x;
                TankY       <= next_y;
                Blocked     <= clamp;
                Moving      <= ~clamp;
            end else begin
                state   <= S_IDLE;
                Moving  <= 1'b0;
                Blocked <= 1'b0;
            end

            if (key_fire && cooldown == '0) begin
                Fire     <= 1'b1;
                cooldown <= CD_LOAD;
            end else begin
                Fire <= 1'b0;
                if (cooldown != '0) cooldown <= cooldown - CD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tank_ctrl.sv
// Bench for tank_ctrl: a default WASD instance and a sticky ARROWS instance starting near the left wall.
module tb_tank_ctrl;
    import tank_pkg::*;

    localparam int T_STEP = 4;
    localparam int T_XMIN = 0;
    localparam int T_XMAX = 608;
    localparam int T_YMIN = 0;
    localparam int T_YMAX = 448;
    localparam int T_CD   = 30;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [47:0] keys_a, keys_b;
    logic [9:0]  a_x, a_y, b_x, b_y;
    dir_t        a_face, b_face;
    logic        a_mov, a_blk, a_fire, b_mov, b_blk, b_fire;

    always #5 frame_clk = ~frame_clk;

    tank_ctrl dut_a (
        .frame_clk (frame_clk), .Reset (Reset), .keycodes (keys_a),
        .TankX (a_x), .TankY (a_y), .Facing (a_face),
        .Moving (a_mov), .Blocked (a_blk), .Fire (a_fire)
    );

    tank_ctrl #(.X_INIT(10'd2), .KEYMAP(KEYS_ARROWS), .STICKY(1'b1)) dut_b (
        .frame_clk (frame_clk), .Reset (Reset), .keycodes (keys_b),
        .TankX (b_x), .TankY (b_y), .Facing (b_face),
        .Moving (b_mov), .Blocked (b_blk), .Fire (b_fire)
    );

    typedef struct {
        int x; int y; int facing; int moving; int blocked; int fire; int cd; int latched;
    } mdl_t;

    typedef struct {
        logic [47:0] keys;
        int x; int y; int face; int mov; int blk; int fire;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    mdl_t ma, mb;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset(input int x0, input int y0);
        mdl_t m;
        m.x = x0; m.y = y0; m.facing = 0; m.moving = 0; m.blocked = 0;
        m.fire = 0; m.cd = 0; m.latched = -1;
        return m;
    endfunction

    // One frame of the tank rules: pick a direction, step, clamp to the window, then fire.
    function automatic mdl_t mdl_step(input mdl_t m, input logic [47:0] keys,
                                      input keymap_t km, input bit sticky);
        bit u, d, l, r, f, blk;
        int dir, tx, ty;
        logic [7:0] c;
        u = 0; d = 0; l = 0; r = 0; f = 0;
        for (int i = 0; i < 6; i++) begin
            c = keys[8*i +: 8];
            if (c != 8'h00) begin
                if (c == km.up)    u = 1;
                if (c == km.down)  d = 1;
                if (c == km.left)  l = 1;
                if (c == km.right) r = 1;
                if (c == km.fire)  f = 1;
            end
        end
        dir = u ? 0 : d ? 1 : l ? 2 : r ? 3 : (sticky ? m.latched : -1);
        if (dir >= 0) begin
            tx = m.x; ty = m.y; blk = 0;
            case (dir)
                0: ty = ty - T_STEP;
                1: ty = ty + T_STEP;
                2: tx = tx - T_STEP;
                default: tx = tx + T_STEP;
            endcase
            if (tx < T_XMIN) begin tx = T_XMIN; blk = 1; end
            if (tx > T_XMAX) begin tx = T_XMAX; blk = 1; end
            if (ty < T_YMIN) begin ty = T_YMIN; blk = 1; end
            if (ty > T_YMAX) begin ty = T_YMAX; blk = 1; end
            m.x = tx; m.y = ty; m.facing = dir; m.latched = dir;
            m.blocked = blk; m.moving = !blk;
        end else begin
            m.moving = 0; m.blocked = 0;
        end
        if (f && m.cd == 0) begin
            m.fire = 1; m.cd = T_CD;
        end else begin
            m.fire = 0;
            if (m.cd > 0) m.cd--;
        end
        return m;
    endfunction

    task automatic compare(input string tag);
        check({tag, ".a.x"},    int'(a_x),    ma.x);
        check({tag, ".a.y"},    int'(a_y),    ma.y);
        check({tag, ".a.face"}, int'(a_face), ma.facing);
        check({tag, ".a.mov"},  int'(a_mov),  ma.moving);
        check({tag, ".a.blk"},  int'(a_blk),  ma.blocked);
        check({tag, ".a.fire"}, int'(a_fire), ma.fire);
        check({tag, ".b.x"},    int'(b_x),    mb.x);
        check({tag, ".b.y"},    int'(b_y),    mb.y);
        check({tag, ".b.face"}, int'(b_face), mb.facing);
        check({tag, ".b.mov"},  int'(b_mov),  mb.moving);
        check({tag, ".b.blk"},  int'(b_blk),  mb.blocked);
        check({tag, ".b.fire"}, int'(b_fire), mb.fire);
    endtask

    task automatic step(input string tag);
        @(posedge frame_clk);
        ma = mdl_step(ma, keys_a, KEYS_WASD, 1'b0);
        mb = mdl_step(mb, keys_b, KEYS_ARROWS, 1'b1);
        #1;
        compare(tag);
    endtask

    task automatic do_reset();
        #1 Reset = 1'b1;
        #1;
        ma = mdl_reset(32, 416);
        mb = mdl_reset(2, 416);
        compare("rst");
        Reset = 1'b0;
    endtask

    function automatic logic [47:0] slot(input logic [7:0] code, input int i);
        logic [47:0] v;
        v = '0;
        v[8*i +: 8] = code;
        return v;
    endfunction

    function automatic logic [47:0] rand_keys();
        logic [7:0]  pool [11];
        logic [47:0] v;
        int          r;
        pool = '{8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h28, 8'h33};
        v = '0;
        for (int i = 0; i < 6; i++) begin
            r = int'($urandom_range(0, 21));
            if (r < 9)       v[8*i +: 8] = 8'h00;
            else if (r < 20) v[8*i +: 8] = pool[r - 9];
            else             v[8*i +: 8] = 8'($urandom_range(1, 255));
        end
        return v;
    endfunction

    vec_t vt [11];
    int   exp_y, n;

    initial begin
        Reset  = 1'b1;
        keys_a = '0;
        keys_b = '0;
        ma = mdl_reset(32, 416);
        mb = mdl_reset(2, 416);
        #12;
        check("reset.x",    int'(a_x),    32);
        check("reset.y",    int'(a_y),    416);
        check("reset.face", int'(a_face), 0);
        check("reset.fire", int'(a_fire), 0);
        compare("reset");
        Reset = 1'b0;

        // {keys, x, y, facing, moving, blocked, fire} for the WASD instance
        vt[0]  = '{slot(8'h07, 3),                  36, 416, 3, 1, 0, 0};
        vt[1]  = '{slot(8'h07, 3),                  40, 416, 3, 1, 0, 0};
        vt[2]  = '{slot(8'h07, 3),                  44, 416, 3, 1, 0, 0};
        vt[3]  = '{48'h0,                           44, 416, 3, 0, 0, 0};
        vt[4]  = '{slot(8'h1A, 0) | slot(8'h04, 5), 44, 412, 0, 1, 0, 0};
        vt[5]  = '{slot(8'h16, 1),                  44, 416, 1, 1, 0, 0};
        vt[6]  = '{slot(8'h2C, 2) | slot(8'h07, 4), 48, 416, 3, 1, 0, 1};
        vt[7]  = '{slot(8'h2C, 2) | slot(8'h07, 4), 52, 416, 3, 1, 0, 0};
        vt[8]  = '{slot(8'h04, 0) | slot(8'h04, 1), 48, 416, 2, 1, 0, 0};
        vt[9]  = '{slot(8'h52, 0),                  48, 416, 2, 0, 0, 0};
        vt[10] = '{slot(8'h16, 5),                  48, 420, 1, 1, 0, 0};
        for (int i = 0; i < 11; i++) begin
            keys_a = vt[i].keys;
            step("vec");
            check($sformatf("vec%0d.x", i),    int'(a_x),    vt[i].x);
            check($sformatf("vec%0d.y", i),    int'(a_y),    vt[i].y);
            check($sformatf("vec%0d.face", i), int'(a_face), vt[i].face);
            check($sformatf("vec%0d.mov", i),  int'(a_mov),  vt[i].mov);
            check($sformatf("vec%0d.blk", i),  int'(a_blk),  vt[i].blk);
            check($sformatf("vec%0d.fire", i), int'(a_fire), vt[i].fire);
        end
        keys_a = '0;

        // Async reset in the middle of a move, between clock edges.
        do_reset();
        keys_a = slot(8'h07, 3);
        step("mv");
        step("mv");
        #2 Reset = 1'b1;
        #1;
        check("async_rst.x",    int'(a_x),    32);
        check("async_rst.y",    int'(a_y),    416);
        check("async_rst.face", int'(a_face), 0);
        check("async_rst.mov",  int'(a_mov),  0);
        ma = mdl_reset(32, 416);
        mb = mdl_reset(2, 416);
        compare("async_rst");
        keys_a = '0;
        Reset  = 1'b0;

        // Held fire: pulses on frames 0, 31, 62 only.
        keys_a = slot(8'h2C, 2);
        for (int i = 0; i < 70; i++) begin
            step("fire");
            check($sformatf("fire.frame%0d", i), int'(a_fire),
                  (i == 0 || i == 31 || i == 62) ? 1 : 0);
        end
        keys_a = '0;

        // Sticky ARROWS instance: left clamp from X=2, then a one-frame down tap.
        do_reset();
        keys_b = slot(8'h50, 0);
        step("clampL");
        check("clampL.x",    int'(b_x),    0);
        check("clampL.blk",  int'(b_blk),  1);
        check("clampL.mov",  int'(b_mov),  0);
        check("clampL.face", int'(b_face), 2);
        step("clampL2");
        check("clampL2.x",   int'(b_x),    0);
        keys_b = '0;
        step("stickyL");
        check("stickyL.x",   int'(b_x),    0);
        check("stickyL.blk", int'(b_blk),  1);
        keys_b = slot(8'h51, 2);
        step("tap");
        check("tap.y",    int'(b_y),    420);
        check("tap.face", int'(b_face), 1);
        check("tap.mov",  int'(b_mov),  1);
        keys_b = '0;
        exp_y = 420;
        n = 0;
        while (exp_y < 448 && n < 20) begin
            step("glide");
            exp_y = (exp_y + 4 > 448) ? 448 : exp_y + 4;
            check("glide.y", int'(b_y), exp_y);
            n++;
        end
        check("glide.frames", n, 7);
        step("bottom");
        check("bottom.y",   int'(b_y),   448);
        check("bottom.blk", int'(b_blk), 1);
        check("bottom.mov", int'(b_mov), 0);

        // Random key soup on both instances against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            keys_a = rand_keys();
            keys_b = rand_keys();
            step("rand");
            if ($urandom_range(0, 99) == 0) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tank_ctrl.md
Name: tank_ctrl

Overview:
- Parametrised per-player tank controller. Replaces the fixed single-key, unbounded tank mover.
- Each frame it scans up to NUM_KEYS simultaneous USB HID keycodes and resolves a movement direction.
- Updates the tank position by STEP, clamped to a playfield window, and tracks facing direction.
- Issues rate-limited fire pulses to the projectile logic. One instance per player; its X/Y/facing outputs feed the sprite drawer and the projectile spawner.

Parameters:
- X_INIT, 10'd32: X position loaded on reset.
- Y_INIT, 10'd416: Y position loaded on reset.
- STEP, 4: pixels moved per frame while a direction is active (1..15).
- X_MIN, 0; X_MAX, 608: legal range for TankX, inclusive.
- Y_MIN, 0; Y_MAX, 448: legal range for TankY, inclusive.
- NUM_KEYS, 6: keycode slots scanned per frame (1..6).
- KEYMAP, tank_pkg::KEYS_WASD: selects the key set, KEYS_WASD or KEYS_ARROWS.
- STICKY, 0: 1 = keep moving in the last direction after keys release; 0 = stop on release.
- COOLDOWN, 30: frames between accepted fire pulses.

Ports:
- frame_clk  in  1  Frame-rate clock (vsync); all state updates on its rising edge.
- Reset  in  1  Asynchronous reset, active-high.
- keycodes  in  8*NUM_KEYS  Packed HID keycodes; slot i = bits [8i+7:8i]; 8'h00 = empty slot.
- TankX  out  10  Tank left-edge X position.
- TankY  out  10  Tank top-edge Y position.
- Facing  out  2  tank_pkg::dir_t; last direction moved.
- Moving  out  1  High when position changed on the last edge.
- Blocked  out  1  High when the last update was clamped at a bound.
- Fire  out  1  One-frame pulse: shot accepted.

Behaviour:
- Reset (async, any time, including mid-cooldown or mid-move):
  - TankX=X_INIT, TankY=Y_INIT, Facing=DIR_UP.
  - Moving=0, Blocked=0, Fire=0.
  - Cooldown counter=0; latched direction = none.
- Key decode: combinational, over all NUM_KEYS slots; a key is pressed if any slot matches it. Duplicates are harmless.
- Direction priority when several are pressed: UP > DOWN > LEFT > RIGHT. Diagonals are never produced.
- Motion state machine, states IDLE and MOVE:
  - IDLE -> MOVE when any direction key is pressed; that direction is latched.
  - In MOVE, a new pressed direction replaces the latched one on the same edge.
  - MOVE -> IDLE when no direction key is pressed and STICKY=0. With STICKY=1, MOVE persists until Reset.
- Position update latency is zero frames: the key present before edge n affects the position at edge n. This removes the previous one-frame motion lag.
- Arithmetic is unsigned, 10-bit. Every bound check is done before the add/subtract, so no wrap-around occurs:
  - Up: if TankY < Y_MIN+STEP then TankY=Y_MIN, Blocked=1; else TankY-=STEP.
  - Down: if TankY > Y_MAX-STEP then TankY=Y_MAX, Blocked=1; else TankY+=STEP.
  - Left and right on X follow the same rules with X_MIN and X_MAX.
- Blocked=0 whenever a move is not clamped or no move occurs.
- Moving=1 only if the position actually changed. At a bound, with a key held, Moving=0 and Blocked=1.
- Facing updates to the active direction even when blocked, and holds in IDLE.
- Fire and cooldown:
  - If the fire key is pressed and cooldown==0: Fire=1 for one frame, cooldown=COOLDOWN.
  - Otherwise the cooldown decrements while nonzero, saturating at 0.
  - Holding fire produces one pulse every COOLDOWN+1 frames.
  - Fire and move on the same frame are independent; both take effect.
- Unknown or unmapped keycodes are ignored.

Decomposition:
- tank_pkg (shared) holds:
  - typedef enum logic[1:0] dir_t {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}.
  - keymap_t struct {up, down, left, right, fire} of 8-bit codes.
  - Constant KEYS_WASD = {8'h1A, 8'h16, 8'h04, 8'h07, 8'h2C (space)}.
  - Constant KEYS_ARROWS = {8'h52, 8'h51, 8'h50, 8'h4F, 8'h28 (enter)}.
  - Playfield bound constants.
- Sub-module tank_key_decode: combinational. Inputs: keycodes and KEYMAP. Outputs: up, down, left, right, fire flags. Reused by the turret block.

Test Plan:
- Reset with defaults -> TankX=32, TankY=416, Facing=UP, Fire=0; assert Reset while moving -> outputs return to these values immediately, without waiting for frame_clk.
- WASD, 'D' (8'h07) in slot 3 for 3 frames -> TankX 32→36→40→44, Facing=RIGHT, Moving=1; release with STICKY=0 -> TankX holds at 44, Moving=0.
- 'W' and 'A' pressed together (slots 0 and 5) -> only TankY decreases by 4; Facing=UP (priority check).
- TankX=2, hold 'A', STEP=4 -> TankX=0, Blocked=1, Moving=0 on that edge; further frames hold TankX=0 with no wrap to 1020.
- Hold space for 70 frames, COOLDOWN=30 -> Fire pulses on frames 0, 31, 62 only, each exactly one frame wide.
- ARROWS map, STICKY=1, tap 8'h51 for one frame -> TankY keeps increasing by 4 per frame until clamped at 448; Blocked=1 there.
